// File: rtl/player_speed_ctrl.sv
// player_speed_ctrl: per-player movement speed level for the Bomber-Man logic.
// Each player has a persistent base level plus a timed power-up boost.
// Build option: define SPEED_DEBUG_SW_EN to enable the sw_inc/sw_dec debug
// switches. Without it the base level stays at DEFAULT_LEVEL.
module player_speed_ctrl #(
  parameter int unsigned NUM_PLAYERS   = 2,
  parameter int unsigned LEVEL_W       = 2,
  parameter int unsigned MAX_LEVEL     = 2,
  parameter int unsigned DEFAULT_LEVEL = 0,
  parameter int unsigned BOOST_FRAMES  = 300,
  parameter int unsigned BOOST_STEP    = 1
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           startOfFrame,
  input  logic [NUM_PLAYERS-1:0]         sw_inc,
  input  logic [NUM_PLAYERS-1:0]         sw_dec,
  input  logic [NUM_PLAYERS-1:0]         powerUp_inc,
  output logic [NUM_PLAYERS*LEVEL_W-1:0] speed_level,
  output logic [NUM_PLAYERS-1:0]         boost_active,
  output logic [NUM_PLAYERS*16-1:0]      boost_frames_left
);

  typedef enum logic {IDLE, BOOSTED} boost_state_t;

  boost_state_t       state_q [NUM_PLAYERS];
  boost_state_t       state_d [NUM_PLAYERS];
  logic [15:0]        timer_q [NUM_PLAYERS];
  logic [15:0]        timer_d [NUM_PLAYERS];
  logic [LEVEL_W-1:0] base_q  [NUM_PLAYERS];
  logic [LEVEL_W-1:0] base_d  [NUM_PLAYERS];
  logic [LEVEL_W:0]   sum_d   [NUM_PLAYERS];
  logic [LEVEL_W-1:0] lvl_d   [NUM_PLAYERS];
  logic [LEVEL_W-1:0] lvl_q   [NUM_PLAYERS];

  logic [NUM_PLAYERS-1:0] pu_q;
  logic [NUM_PLAYERS-1:0] pu_ev;

  assign pu_ev = powerUp_inc & ~pu_q;

`ifdef SPEED_DEBUG_SW_EN
  logic [NUM_PLAYERS-1:0] inc_q;
  logic [NUM_PLAYERS-1:0] dec_q;
  logic [NUM_PLAYERS-1:0] inc_ev;
  logic [NUM_PLAYERS-1:0] dec_ev;

  assign inc_ev = sw_inc & ~inc_q;
  assign dec_ev = sw_dec & ~dec_q;

  // Debug switch edge registers and persistent base level.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      inc_q <= '0;
      dec_q <= '0;
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) base_q[p] <= LEVEL_W'(DEFAULT_LEVEL);
    end else begin
      inc_q <= sw_inc;
      dec_q <= sw_dec;
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) base_q[p] <= base_d[p];
    end
  end

  // Saturating base adjust; simultaneous inc and dec cancel.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      base_d[p] = base_q[p];
      if (inc_ev[p] && !dec_ev[p] && (base_q[p] < LEVEL_W'(MAX_LEVEL)))
        base_d[p] = base_q[p] + 1'b1;
      else if (dec_ev[p] && !inc_ev[p] && (base_q[p] != '0))
        base_d[p] = base_q[p] - 1'b1;
    end
  end
`else
  logic unused_sw;
  assign unused_sw = ^{sw_inc, sw_dec};

  // Base level is fixed when the debug switches are compiled out.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      base_q[p] = LEVEL_W'(DEFAULT_LEVEL);
      base_d[p] = LEVEL_W'(DEFAULT_LEVEL);
    end
  end
`endif

  // Boost FSM state, timer, power-up edge register and registered level.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pu_q <= '0;
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
        state_q[p] <= IDLE;
        timer_q[p] <= '0;
        lvl_q[p]   <= LEVEL_W'(DEFAULT_LEVEL);
      end
    end else begin
      pu_q <= powerUp_inc;
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
        state_q[p] <= state_d[p];
        timer_q[p] <= timer_d[p];
        lvl_q[p]   <= lvl_d[p];
      end
    end
  end

  // Boost next-state: power-up reload wins over the frame tick.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      state_d[p] = state_q[p];
      timer_d[p] = timer_q[p];
      if (pu_ev[p]) begin
        state_d[p] = BOOSTED;
        timer_d[p] = 16'(BOOST_FRAMES);
      end else if ((state_q[p] == BOOSTED) && startOfFrame) begin
        timer_d[p] = timer_q[p] - 16'd1;
        if (timer_q[p] == 16'd1) state_d[p] = IDLE;
      end
    end
  end

  // Effective level from next-cycle base and boost, clamped at MAX_LEVEL.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      sum_d[p] = {1'b0, base_d[p]} +
                 ((state_d[p] == BOOSTED) ? (LEVEL_W+1)'(BOOST_STEP) : '0);
      if (sum_d[p] > (LEVEL_W+1)'(MAX_LEVEL)) lvl_d[p] = LEVEL_W'(MAX_LEVEL);
      else                                    lvl_d[p] = sum_d[p][LEVEL_W-1:0];
    end
  end

  // Pack per-player values onto the flat output buses.
  always_comb begin
    speed_level       = '0;
    boost_active      = '0;
    boost_frames_left = '0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      speed_level[p*LEVEL_W +: LEVEL_W] = lvl_q[p];
      boost_active[p]                   = (state_q[p] == BOOSTED);
      boost_frames_left[p*16 +: 16]     = timer_q[p];
    end
  end

endmodule
